// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller.
// Holds the digit count, code width, FSM state encoding and a helper that
// builds the active-low one-hot digit enable.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = 4;
    localparam int IDX_W      = 2;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // Active-low one-hot enable for digit idx.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot_n(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return ~oh;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Load handshake between a display-contents source and the scan controller.
// Handshake: a transfer occurs on a rising clk edge where load_valid and
// load_ready are both 1. load_ready never depends on load_valid. While
// load_ready is 0 the source holds load_valid/load_data/blank_mask stable.
//   load_valid : source -> ctrl, new contents offered
//   load_ready : ctrl -> source, pending buffer empty
//   load_data  : source -> ctrl, four codes, digit0 in [3:0]
//   blank_mask : source -> ctrl, bit i = 1 keeps digit i dark
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    logic                          load_valid;
    logic                          load_ready;
    logic [NUM_DIGITS*CODE_W-1:0]  load_data;
    logic [NUM_DIGITS-1:0]         blank_mask;

    modport master (
        output load_valid,
        output load_data,
        output blank_mask,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  blank_mask,
        output load_ready
    );

endinterface

// File: rtl/disp_scan_ctrl_timer.sv
// scan_timer: loadable down-counter with terminal-count output.
// The counter stops at zero; tc_o is high while the count is zero. A load
// takes priority over counting, so loading on tc gives an interval of
// load_val_i+1 clocks.
//   clk, rst_n  : clock, async active-low reset (count -> RST_VAL)
//   load_i      : load load_val_i on the next edge
//   load_val_i  : reload value
//   tc_o        : terminal count (count == 0)
module scan_timer #(
    parameter int              CNT_W   = 2,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 4-digit display scanner.
// Cycles SHOW(digit i) -> BLANK -> SHOW(digit i+1) ... with a pending
// buffer that is copied into the active registers only at frame start,
// so a frame is never torn.
//   clk, rst_n    : clock, async active-low reset
//   load_if       : load handshake (slave side)
//   code          : registered code of the current digit
//   digit_en_n    : registered one-hot-low digit enable, 1111 = all off
//   frame_tick    : one-cycle pulse on the BLANK(3) -> SHOW(0) edge
//   dbg_state_o   : current FSM state
//   dbg_idx_o     : current digit index
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    disp_scan_ctrl_if.slave        load_if,
    output logic [CODE_W-1:0]      code,
    output logic [NUM_DIGITS-1:0]  digit_en_n,
    output logic                   frame_tick,
    output scan_state_e            dbg_state_o,
    output logic [IDX_W-1:0]       dbg_idx_o
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);

    typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] codes_t;

    scan_state_e           state_q,      state_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [CODE_W-1:0]     code_q,       code_d;
    logic [NUM_DIGITS-1:0] en_n_q,       en_n_d;
    logic                  tick_q,       tick_d;
    codes_t                act_code_q,   act_code_d;
    logic [NUM_DIGITS-1:0] act_mask_q,   act_mask_d;
    codes_t                pend_code_q,  pend_code_d;
    logic [NUM_DIGITS-1:0] pend_mask_q,  pend_mask_d;
    logic                  pend_full_q,  pend_full_d;

    logic                  tc;
    logic                  timer_load;
    logic [CNT_W-1:0]      timer_val;

    scan_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (BLANK_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (tc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        en_n_d      = en_n_q;
        tick_d      = 1'b0;
        act_code_d  = act_code_q;
        act_mask_d  = act_mask_q;
        pend_code_d = pend_code_q;
        pend_mask_d = pend_mask_q;
        pend_full_d = pend_full_q;
        timer_load  = 1'b0;
        timer_val   = BLANK_LD;

        if (tc) begin
            timer_load = 1'b1;
            if (state_q == ST_SHOW) begin
                state_d   = ST_BLANK;
                en_n_d    = '1;
                timer_val = BLANK_LD;
            end else begin
                state_d   = ST_SHOW;
                idx_d     = idx_q + 1'b1;
                timer_val = SHOW_LD;
                // Frame start: the only point where active contents may change.
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    tick_d = 1'b1;
                    if (pend_full_q) begin
                        act_code_d  = pend_code_q;
                        act_mask_d  = pend_mask_q;
                        pend_full_d = 1'b0;
                    end
                end
                // Use the post-transfer contents so the new frame's first digit is right.
                code_d = act_code_d[idx_d];
                en_n_d = act_mask_d[idx_d] ? '1 : digit_onehot_n(idx_d);
            end
        end

        // Accept only into an empty buffer; a transfer needs a full one,
        // so the two never happen on the same edge.
        if (load_if.load_valid && !pend_full_q) begin
            pend_code_d = load_if.load_data;
            pend_mask_d = load_if.blank_mask;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            idx_q       <= IDX_W'(NUM_DIGITS - 1);
            code_q      <= '0;
            en_n_q      <= '1;
            tick_q      <= 1'b0;
            act_code_q  <= '0;
            act_mask_q  <= '1;
            pend_code_q <= '0;
            pend_mask_q <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            en_n_q      <= en_n_d;
            tick_q      <= tick_d;
            act_code_q  <= act_code_d;
            act_mask_q  <= act_mask_d;
            pend_code_q <= pend_code_d;
            pend_mask_q <= pend_mask_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign load_if.load_ready = ~pend_full_q;
    assign code               = code_q;
    assign digit_en_n         = en_n_q;
    assign frame_tick         = tick_q;
    assign dbg_state_o        = state_q;
    assign dbg_idx_o          = idx_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SHOW_CYCLES=4, BLANK_CYCLES=2.
// k counts rising edges since reset release; outputs are sampled on the
// following falling edge. Frame f starts at edge 2+24*f and the expected
// contents of each frame are written into fd/fm by hand.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [CODE_W-1:0]     code;
    logic [NUM_DIGITS-1:0] digit_en_n;
    logic                  frame_tick;
    scan_state_e           dbg_state;
    logic [IDX_W-1:0]      dbg_idx;

    int total;
    int bad;
    int k;

    logic [15:0] fd [0:5];
    logic [3:0]  fm [0:5];

    disp_scan_ctrl_if load_if ();

    disp_scan_ctrl #(
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_if     (load_if),
        .code        (code),
        .digit_en_n  (digit_en_n),
        .frame_tick  (frame_tick),
        .dbg_state_o (dbg_state),
        .dbg_idx_o   (dbg_idx)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp_v);
        end
    endtask

    // Expected outputs after edge k from the hand-filled frame table.
    task automatic check_cycle();
        int f, p, d;
        logic [15:0] dv;
        logic [3:0]  mv;
        logic [3:0]  exp_en;
        logic [3:0]  exp_code;
        logic        shw;
        if (k < 2) begin
            chk("pre_en",   16'(digit_en_n), 16'hF);
            chk("pre_code", 16'(code),       16'h0);
            chk("pre_tick", 16'(frame_tick), 16'h0);
        end else begin
            f = (k - 2) / 24;
            if (f > 5) f = 5;
            p   = (k - 2) % 24;
            d   = p / 6;
            shw = (p % 6) < 4;
            dv  = fd[f];
            mv  = fm[f];
            exp_code = dv[d*4 +: 4];
            exp_en   = 4'hF;
            if (shw && !mv[d]) exp_en[d] = 1'b0;
            chk("en",    16'(digit_en_n), 16'(exp_en));
            chk("code",  16'(code),       16'(exp_code));
            chk("tick",  16'(frame_tick), (p == 0) ? 16'h1 : 16'h0);
            chk("state", 16'(dbg_state),  shw ? 16'(ST_SHOW) : 16'(ST_BLANK));
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},    16'(digit_en_n),          16'hF);
        chk({tag, "_code"},  16'(code),                16'h0);
        chk({tag, "_tick"},  16'(frame_tick),          16'h0);
        chk({tag, "_ready"}, 16'(load_if.load_ready),  16'h1);
        chk({tag, "_state"}, 16'(dbg_state),           16'(ST_BLANK));
        chk({tag, "_idx"},   16'(dbg_idx),             16'h3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        k     = 0;
        load_if.load_valid = 1'b0;
        load_if.load_data  = 16'h0;
        load_if.blank_mask = 4'h0;
        rst_n = 1'b1;

        // Frame table: frame0 dark, frame1 4321, frame2 1111, frame3 2222,
        // frame4 still 2222 (load landed on frame_tick edge), frame5 9876 mask 0100.
        fd[0] = 16'h0000; fm[0] = 4'hF;
        fd[1] = 16'h4321; fm[1] = 4'h0;
        fd[2] = 16'h1111; fm[2] = 4'h0;
        fd[3] = 16'h2222; fm[3] = 4'h0;
        fd[4] = 16'h2222; fm[4] = 4'h0;
        fd[5] = 16'h9876; fm[5] = 4'h4;

        // reset
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0_hold");
        rst_n = 1'b1;
        k = 0;

        // Load 4321 during frame 0.
        run_to(3);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h4321;
        load_if.blank_mask = 4'h0;
        step();
        load_if.load_valid = 1'b0;
        chk("rdy_after_load1", 16'(load_if.load_ready), 16'h0);
        run_to(25);
        chk("rdy_before_xfer1", 16'(load_if.load_ready), 16'h0);
        step();
        chk("rdy_after_xfer1", 16'(load_if.load_ready), 16'h1);

        // Back-to-back loads 1111 then 2222.
        run_to(27);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h1111;
        step();
        chk("rdy_after_b2b1", 16'(load_if.load_ready), 16'h0);
        load_if.load_data  = 16'h2222;
        run_to(49);
        chk("rdy_held_low", 16'(load_if.load_ready), 16'h0);
        step();
        chk("rdy_at_tick2", 16'(load_if.load_ready), 16'h1);
        step();
        chk("rdy_after_b2b2", 16'(load_if.load_ready), 16'h0);
        load_if.load_valid = 1'b0;
        run_to(74);
        chk("rdy_after_xfer3", 16'(load_if.load_ready), 16'h1);

        // Load accepted on the frame_tick edge 98.
        run_to(97);
        chk("rdy_before_tick4", 16'(load_if.load_ready), 16'h1);
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h9876;
        load_if.blank_mask = 4'h4;
        step();
        chk("rdy_tick_edge_load", 16'(load_if.load_ready), 16'h0);
        load_if.load_valid = 1'b0;
        run_to(122);
        chk("rdy_after_xfer5", 16'(load_if.load_ready), 16'h1);

        // Pending 5555 then reset mid-SHOW of digit 1.
        load_if.load_valid = 1'b1;
        load_if.load_data  = 16'h5555;
        load_if.blank_mask = 4'h0;
        step();
        load_if.load_valid = 1'b0;
        chk("rdy_pend5555", 16'(load_if.load_ready), 16'h0);
        run_to(129);
        chk("pre_rst_en",   16'(digit_en_n), 16'hD);
        chk("pre_rst_code", 16'(code),       16'h7);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst1_async");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst1_hold");
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            fd[i] = 16'h0000;
            fm[i] = 4'hF;
        end
        step();
        chk("rst1_rdy", 16'(load_if.load_ready), 16'h1);
        run_to(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter: SHOW_CYCLES, 50000, number of clocks each digit is enabled (legal range >= 1).
REQ-002 Parameter: BLANK_CYCLES, 500, number of all-off clocks between digits, for anti-ghosting (legal range >= 1).
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port: load_valid, input, 1, new display contents offered.
REQ-006 Port: load_ready, output, 1, pending buffer empty, so a load can be accepted.
REQ-007 Port: load_data, input, 16, four 4-bit codes; digit0 = [3:0], digit3 = [15:12].
REQ-008 Port: blank_mask, input, 4, per-digit blank request, captured with load_data; bit i = 1 keeps digit i dark.
REQ-009 Port: code, output, 4, current digit code {A,B,C,D} to the downstream 7-segment decoder; A = bit 3.
REQ-010 Port: digit_en_n, output, 4, one-hot-low digit enable; 1111 = all off.
REQ-011 Port: frame_tick, output, 1, one-cycle pulse at each frame start.

Function
REQ-012 The FSM SHALL have two states: SHOW (one digit active) and BLANK (all digits off).
REQ-013 SHOW SHALL last exactly SHOW_CYCLES clocks and then go to BLANK with the same digit index.
REQ-014 BLANK SHALL last exactly BLANK_CYCLES clocks and then go to SHOW with digit index incremented modulo 4 (3 wraps to 0).
REQ-015 Frame period SHALL be exactly 4*(SHOW_CYCLES+BLANK_CYCLES) clocks, independent of loads and masks.
REQ-016 In SHOW of digit i, code SHALL equal active code i.
REQ-017 In SHOW of digit i, digit_en_n bit i SHALL be 0 and all other bits 1, unless active mask bit i = 1, in which case digit_en_n SHALL be 1111.
REQ-018 In BLANK, digit_en_n SHALL be 1111 and code SHALL hold its last value.
REQ-019 code and digit_en_n SHALL be registered and change on the same edge as the state change; there is no combinational path from inputs to them.
REQ-020 A load is accepted when load_valid and load_ready are both 1 on a rising edge; load_data and blank_mask are written to the pending buffer.
REQ-021 load_ready SHALL be the inverse of the pending-full flag (no combinational dependence on load_valid).
REQ-022 On the BLANK(idx 3) -> SHOW(idx 0) edge, frame_tick SHALL be 1 for one cycle; if the pending buffer is full, it SHALL be copied into the active registers on that edge and the buffer cleared.
REQ-023 The active registers SHALL never change mid-frame.
REQ-024 A load accepted on the same edge as a frame transfer (buffer empty beforehand) SHALL be held pending until the next frame start.
REQ-025 While load_ready = 0, load_valid and load_data SHALL be ignored; the source holds them.

Reset
REQ-026 Asserting rst_n low SHALL immediately, asynchronously, force:
- digit_en_n = 1111, code = 0000, frame_tick = 0, load_ready = 1
- pending cleared, active codes = 0, active mask = 1111
- state = BLANK, digit index = 3, timer reloaded
REQ-027 Reset in the middle of a SHOW or BLANK interval, or while a load is pending, SHALL discard all in-progress state.
REQ-028 The first frame_tick after reset release SHALL occur BLANK_CYCLES clocks after the first rising edge with rst_n high.

Structure
REQ-029 Shared package disp_pkg SHALL hold NUM_DIGITS = 4, CODE_W = 4 and the SHOW/BLANK state enum.
REQ-030 One sub-module, scan_timer, SHALL be used: a loadable down-counter with terminal-count output, sized by $clog2 of the larger interval.
REQ-031 disp_scan_ctrl SHALL NOT instantiate the 7-segment decoder; code feeds it externally.

Verification (SHOW_CYCLES = 4, BLANK_CYCLES = 2)
REQ-032 Reset release, no load -> digit_en_n stays 1111 and code = 0; frame_tick at cycle 2, then every 24 cycles.
REQ-033 Load 16'h4321 with mask 0000 -> from the next frame_tick: 1110/code 1 for 4 cycles, 1111 for 2, then 1101/code 2, 1011/code 3, 0111/code 4.
REQ-034 Two back-to-back loads (16'h1111, then 16'h2222) -> load_ready drops after the first; the second is accepted on the cycle after the next frame_tick and is displayed one frame later.
REQ-035 Mask 0100 with data 16'h9876 -> digit 2 stays dark for its 4-cycle slot, other digits display normally, frame period stays 24.
REQ-036 Load accepted on the frame_tick edge -> the current frame shows the old data; the new data appears from the following frame_tick.
REQ-037 rst_n pulsed low mid-SHOW of digit 1 with a load pending -> outputs reach reset values without a clock edge; the pending data is never displayed.
